// File: rtl/audio_out_serializer_if.sv
// FIFO-side bundle for the audio output serializer:
// show-ahead head words, empty flags and pop strobes for both channels.
interface audio_out_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] left_channel_data;
    logic                  left_channel_empty;
    logic                  left_channel_read_en;
    logic [DATA_WIDTH-1:0] right_channel_data;
    logic                  right_channel_empty;
    logic                  right_channel_read_en;

    modport master (
        output left_channel_data,
        output left_channel_empty,
        input  left_channel_read_en,
        output right_channel_data,
        output right_channel_empty,
        input  right_channel_read_en
    );

    modport slave (
        input  left_channel_data,
        input  left_channel_empty,
        output left_channel_read_en,
        input  right_channel_data,
        input  right_channel_empty,
        output right_channel_read_en
    );
endinterface

// File: rtl/audio_out_serializer.sv
// Left-justified, MSB-first DAC serializer. Pops one left/right pair
// per LRCK frame; starved frames are zero-filled and counted.
module audio_out_serializer #(
    parameter int DATA_WIDTH     = 16,
    parameter int UNDERRUN_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bit_clk_falling_edge,
    input  logic                      left_right_clk_rising_edge,
    input  logic                      left_right_clk_falling_edge,
    input  logic                      audio_out_enable,
    audio_out_serializer_if.slave     fifo,
    output logic                      serial_audio_out_data,
    output logic [UNDERRUN_WIDTH-1:0] underrun_count
);
    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  left_rd;
    logic                  right_rd;

    logic frame_load;
    logic right_load;
    logic fifo_ready;
    logic count_full;

    // A falling LRCK strobe always wins, so a rising strobe only
    // matters when no frame load is happening and we are mid-left.
    assign frame_load = left_right_clk_falling_edge;
    assign right_load = left_right_clk_rising_edge && (state == LEFT);
    assign fifo_ready = !fifo.left_channel_empty
                     && !fifo.right_channel_empty;
    assign count_full = &underrun_count;

    assign fifo.left_channel_read_en  = left_rd;
    assign fifo.right_channel_read_en = right_rd;
    assign serial_audio_out_data      = shift_reg[DATA_WIDTH-1];

    // Frame sequencing, paired FIFO pops, shifting and underrun count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_SYNC;
            shift_reg      <= '0;
            hold_reg       <= '0;
            left_rd        <= 1'b0;
            right_rd       <= 1'b0;
            underrun_count <= '0;
        end else begin
            left_rd  <= 1'b0;
            right_rd <= 1'b0;
            if (frame_load) begin
                state <= LEFT;
                if (audio_out_enable && fifo_ready) begin
                    shift_reg <= fifo.left_channel_data;
                    hold_reg  <= fifo.right_channel_data;
                    left_rd   <= 1'b1;
                    right_rd  <= 1'b1;
                end else begin
                    // Pop neither side so left/right stay paired.
                    shift_reg <= '0;
                    hold_reg  <= '0;
                    if (audio_out_enable && !count_full) begin
                        underrun_count <= underrun_count + 1'b1;
                    end
                end
            end else if (right_load) begin
                state     <= RIGHT;
                shift_reg <= hold_reg;
            end else if (bit_clk_falling_edge) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_audio_out_serializer.sv
// Randomized bench for audio_out_serializer with a word/bit-index
// reference model and queue-based show-ahead FIFOs.
module tb_audio_out_serializer;
    localparam int DW = 16;
    localparam int UW = 8;
    localparam int CMAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bclk = 1'b0;
    logic          rise = 1'b0;
    logic          fall = 1'b0;
    logic          en = 1'b0;
    logic          serial;
    logic [UW-1:0] ucnt;

    audio_out_serializer_if #(.DATA_WIDTH(DW)) fifo_if ();

    audio_out_serializer #(
        .DATA_WIDTH(DW),
        .UNDERRUN_WIDTH(UW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bit_clk_falling_edge(bclk),
        .left_right_clk_rising_edge(rise),
        .left_right_clk_falling_edge(fall),
        .audio_out_enable(en),
        .fifo(fifo_if.slave),
        .serial_audio_out_data(serial),
        .underrun_count(ucnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];

    // Reference model: the word being sent and how many bits have gone.
    logic [DW-1:0] m_cur;
    logic [DW-1:0] m_right;
    int            m_n;
    int            m_half;
    int            m_cnt;
    bit            m_rd;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        if (reset) begin
            m_cur = '0; m_right = '0; m_n = DW;
            m_half = 0; m_cnt = 0; m_rd = 0;
        end else begin
            m_rd = 0;
            if (fall) begin
                m_half = 1;
                m_n = 0;
                if (en && lq.size() > 0 && rq.size() > 0) begin
                    m_cur = lq[0];
                    m_right = rq[0];
                    m_rd = 1;
                end else begin
                    m_cur = '0;
                    m_right = '0;
                    if (en && m_cnt < CMAX) m_cnt++;
                end
            end else if (rise && m_half == 1) begin
                m_half = 2;
                m_cur = m_right;
                m_n = 0;
            end else if (bclk) begin
                if (m_n < DW) m_n++;
            end
        end
    endfunction

    task automatic step(input bit f, input bit r, input bit b);
        bit pl, pr;
        logic exp_out;
        fall = f; rise = r; bclk = b;
        fifo_if.left_channel_empty = (lq.size() == 0);
        fifo_if.right_channel_empty = (rq.size() == 0);
        fifo_if.left_channel_data = (lq.size() > 0) ? lq[0] : DW'($urandom);
        fifo_if.right_channel_data = (rq.size() > 0) ? rq[0] : DW'($urandom);
        pl = fifo_if.left_channel_read_en;
        pr = fifo_if.right_channel_read_en;
        model_edge();
        @(posedge clk);
        if (pl && lq.size() > 0) void'(lq.pop_front());
        if (pr && rq.size() > 0) void'(rq.pop_front());
        #1;
        exp_out = (m_n < DW) ? m_cur[DW-1-m_n] : 1'b0;
        chk("serial", 32'(serial), 32'(exp_out));
        chk("left_rd", 32'(fifo_if.left_channel_read_en), 32'(m_rd));
        chk("right_rd", 32'(fifo_if.right_channel_read_en), 32'(m_rd));
        chk("underrun", 32'(ucnt), 32'(m_cnt));
        if (fifo_if.left_channel_read_en) rd_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic frame(input int gap, input bit clash,
                         output logic [DW-1:0] cl,
                         output logic [DW-1:0] cr);
        cl = '0; cr = '0;
        step(1, clash, 1);
        cl[DW-1] = serial;
        for (int i = 0; i < DW + 2; i++) begin
            idle(gap); step(0, 0, 1);
            if (i < DW - 1) cl[DW-2-i] = serial;
        end
        idle(gap); step(0, 1, 1);
        cr[DW-1] = serial;
        for (int i = 0; i < DW + 2; i++) begin
            idle(gap); step(0, 0, 1);
            if (i < DW - 1) cr[DW-2-i] = serial;
        end
        idle(gap);
    endtask

    logic [DW-1:0] cl, cr;
    int            nl;

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        // Rising strobe before any frame start must be ignored.
        step(0, 1, 1); idle(2);
        chk("reset_ucnt", 32'(ucnt), 0);
        chk("reset_serial", 32'(serial), 0);

        // Known pair.
        en = 1'b1;
        lq.push_back(16'hA5F0); rq.push_back(16'h0F3C);
        rd_pulses = 0;
        frame(1, 0, cl, cr);
        chk("left_bits", 32'(cl), 32'b1010010111110000);
        chk("right_bits", 32'(cr), 32'b0000111100111100);
        chk("pop_pulses", rd_pulses, 1);
        chk("fifos_drained", lq.size() + rq.size(), 0);

        // Right FIFO empty: starve, keep left word.
        lq.push_back(16'h1234);
        frame(1, 0, cl, cr);
        chk("starve_ucnt", 32'(ucnt), 1);
        chk("starve_bits", 32'({cl, cr}), 0);
        chk("left_kept_n", lq.size(), 1);
        chk("left_kept_w", 32'(lq[0]), 32'h1234);
        lq.delete();

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 0); step(0, 0, 0);
        end
        chk("sat_ucnt", 32'(ucnt), 255);
        step(1, 0, 0); idle(2);
        chk("sat_hold", 32'(ucnt), 255);

        // Disabled with data present, then re-enabled.
        en = 1'b0;
        lq.push_back(16'hBEEF); rq.push_back(16'hCAFE);
        lq.push_back(16'h8001); rq.push_back(16'h7FFE);
        frame(2, 0, cl, cr);
        chk("dis_bits", 32'({cl, cr}), 0);
        chk("dis_kept", lq.size() + rq.size(), 4);
        en = 1'b1;
        frame(1, 0, cl, cr);
        chk("reen_left", 32'(cl), 32'hBEEF);
        chk("reen_right", 32'(cr), 32'hCAFE);

        // Reset mid left word, then a fresh frame.
        step(1, 0, 1);
        for (int i = 0; i < 5; i++) begin idle(1); step(0, 0, 1); end
        reset = 1'b1; step(0, 0, 0); reset = 1'b0;
        chk("mid_rst_serial", 32'(serial), 0);
        chk("mid_rst_ucnt", 32'(ucnt), 0);
        idle(2);
        lq.push_back(16'h6C39); rq.push_back(16'h93C6);
        frame(1, 0, cl, cr);
        chk("post_rst_left", 32'(cl), 32'h6C39);
        chk("post_rst_right", 32'(cr), 32'h93C6);
        lq.delete(); rq.delete();

        // Randomized frames; the model checks every cycle.
        for (int f = 0; f < 40; f++) begin
            en = ($urandom_range(0, 9) < 8);
            nl = $urandom_range(0, 2);
            for (int k = 0; k < nl; k++) lq.push_back(DW'($urandom));
            nl = $urandom_range(0, 2);
            for (int k = 0; k < nl; k++) rq.push_back(DW'($urandom));
            frame($urandom_range(1, 3), ($urandom_range(0, 9) == 0), cl, cr);
            if (f == 20) begin
                reset = 1'b1; step(0, 0, 0); reset = 1'b0; idle(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
